// File: rtl/vga_generator_pkg.sv
// Shared 640x480@60 timing constants, spectrum bar geometry and capture FSM states
// for the FFT spectrum VGA display.
package vga_generator_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CNT_W      = 10;
    localparam int NUM_BARS   = 160;
    localparam int BAR_WIDTH  = 4;
    localparam int BAR_IDX_W  = 8;
    localparam int MAX_HEIGHT = V_VISIBLE;
    localparam int HEIGHT_W   = 9;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_READ  = 2'd1,
        CAP_DRAIN = 2'd2
    } cap_state_e;

endpackage

// File: rtl/vga_generator_timing.sv
// Horizontal/vertical pixel counters with combinational sync and visible-area flags;
// the parent registers everything it drives off-chip.
module vga_timing
    import vga_generator_pkg::*;
(
    input  logic             vga_clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hs_n,
    output logic             vs_n,
    output logic             visible
);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    // next counter values: hc wraps every line, vc advances on the hc wrap
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (hc_q == CNT_W'(H_TOTAL - 1)) begin
            hc_d = '0;
            if (vc_q == CNT_W'(V_TOTAL - 1)) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + CNT_W'(1);
            end
        end else begin
            hc_d = hc_q + CNT_W'(1);
        end
    end

    // counter registers
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc      = hc_q;
    assign vc      = vc_q;
    assign hs_n    = !((hc_q >= CNT_W'(H_SYNC_START)) && (hc_q <= CNT_W'(H_SYNC_END)));
    assign vs_n    = !((vc_q >= CNT_W'(V_SYNC_START)) && (vc_q <= CNT_W'(V_SYNC_END)));
    assign visible = (hc_q < CNT_W'(H_VISIBLE)) && (vc_q < CNT_W'(V_VISIBLE));

endmodule

// File: rtl/vga_generator.sv
// FFT spectrum bar display: captures 160 bin magnitudes during vertical blank and
// draws them as green bars, 4 columns per bar with a black gap column.
module vga_generator
    import vga_generator_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9,
    parameter int MAG_SHIFT  = DATA_WIDTH - 10
) (
    input  logic                         vga_clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic signed [DATA_WIDTH-1:0] FFT_data_r,
    input  logic signed [DATA_WIDTH-1:0] FFT_data_i,
    output logic [ADDR_WIDTH-2:0]        FFT_addr,
    output logic [3:0]                   VGA_R,
    output logic [3:0]                   VGA_G,
    output logic [3:0]                   VGA_B,
    output logic                         VGA_HS,
    output logic                         VGA_VS
);

    localparam int MAG_W = DATA_WIDTH + 1;
    localparam int AW    = ADDR_WIDTH - 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BARS - 1);

    logic [CNT_W-1:0] hc, vc;
    logic             hs_n, vs_n, visible;

    vga_timing u_timing (
        .vga_clk (vga_clk),
        .rst     (rst),
        .hc      (hc),
        .vc      (vc),
        .hs_n    (hs_n),
        .vs_n    (vs_n),
        .visible (visible)
    );

    cap_state_e           state_q, state_d;
    logic                 pending_q, pending_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [BAR_IDX_W-1:0] wr_addr_q, wr_addr_d;
    logic [HEIGHT_W-1:0]  height_q [NUM_BARS];
    logic [HEIGHT_W-1:0]  height_d [NUM_BARS];
    logic                 start_s;
    logic [MAG_W-1:0]     abs_r_s, abs_i_s, mag_s, scaled_s;
    logic [HEIGHT_W-1:0]  new_height_s;
    logic [BAR_IDX_W-1:0] bar_s;
    logic [HEIGHT_W-1:0]  bar_height_s;
    logic                 lit_s;
    logic [3:0]           r_q, r_d, g_q, g_d, b_q, b_d;
    logic                 hs_q, hs_d, vs_q, vs_d;

    // Widening first keeps |-2^(DATA_WIDTH-1)| representable.
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [MAG_W-1:0] w;
        w = MAG_W'(v);
        if (w[MAG_W-1]) begin
            abs_ext = -w;
        end else begin
            abs_ext = w;
        end
    endfunction

    assign start_s = pending_q && (hc == '0) && (vc == CNT_W'(V_VISIBLE));

    // capture FSM state register
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q <= CAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // capture FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAP_IDLE:  if (start_s) state_d = CAP_READ; else state_d = CAP_IDLE;
            CAP_READ:  if (addr_q == LAST_ADDR) state_d = CAP_DRAIN; else state_d = CAP_READ;
            CAP_DRAIN: state_d = CAP_IDLE;
            default:   state_d = CAP_IDLE;
        endcase
    end

    // capture FSM outputs: address stepping, pending flag, delayed write strobe
    always_comb begin
        addr_d    = '0;
        pending_d = pending_q;
        wr_en_d   = (state_q == CAP_READ);
        wr_addr_d = BAR_IDX_W'(addr_q);
        case (state_q)
            CAP_IDLE: begin
                if (start_s) pending_d = 1'b0;
                else if (done) pending_d = 1'b1;
                else pending_d = pending_q;
            end
            CAP_READ: begin
                if (addr_q != LAST_ADDR) addr_d = addr_q + AW'(1);
                else addr_d = '0;
            end
            CAP_DRAIN: addr_d = '0;
            default:   addr_d = '0;
        endcase
    end

    // capture datapath registers
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign FFT_addr = addr_q;

    // L1 magnitude scaled to bar height and clamped to the screen
    always_comb begin
        abs_r_s  = abs_ext(FFT_data_r);
        abs_i_s  = abs_ext(FFT_data_i);
        mag_s    = abs_r_s + abs_i_s;
        scaled_s = mag_s >> MAG_SHIFT;
        if (scaled_s > MAG_W'(MAX_HEIGHT)) begin
            new_height_s = HEIGHT_W'(MAX_HEIGHT);
        end else begin
            new_height_s = scaled_s[HEIGHT_W-1:0];
        end
    end

    // height buffer write port
    always_comb begin
        height_d = height_q;
        if (wr_en_q) begin
            height_d[wr_addr_q] = new_height_s;
        end else begin
            height_d = height_q;
        end
    end

    // height buffer storage
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                height_q[i] <= '0;
            end
        end else begin
            height_q <= height_d;
        end
    end

    // pixel colour; the bar index is parked at 0 in blanking to stay in range
    always_comb begin
        if (visible) begin
            bar_s = hc[CNT_W-1:2];
        end else begin
            bar_s = '0;
        end
        bar_height_s = height_q[bar_s];
        lit_s = visible && (hc[1:0] != 2'd3)
                && (vc >= (CNT_W'(V_VISIBLE) - CNT_W'(bar_height_s)));
        r_d  = 4'h0;
        g_d  = lit_s ? 4'hF : 4'h0;
        b_d  = 4'h0;
        hs_d = hs_n;
        vs_d = vs_n;
    end

    // output stage: colour and syncs share one pipeline register
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_q  <= 4'h0;
            g_q  <= 4'h0;
            b_q  <= 4'h0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign VGA_R  = r_q;
    assign VGA_G  = g_q;
    assign VGA_B  = b_q;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_generator.sv
// Scoreboard bench for vga_generator: a reference model predicts every output cycle;
// counters are fast-forwarded between regions of interest and resynchronised on HS.
module tb_vga_generator;

    localparam int DW = 18;

    logic                 vga_clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 done = 1'b0;
    logic signed [DW-1:0] FFT_data_r = '0;
    logic signed [DW-1:0] FFT_data_i = '0;
    logic [7:0]           FFT_addr;
    logic [3:0]           VGA_R, VGA_G, VGA_B;
    logic                 VGA_HS, VGA_VS;

    vga_generator dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .done       (done),
        .FFT_data_r (FFT_data_r),
        .FFT_data_i (FFT_data_i),
        .FFT_addr   (FFT_addr),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [13:0] pix;
        logic [7:0]  addr;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         mh = 0, mv = 0, mcap = 0;
    bit         mpend = 1'b0;
    int         mheight[160];
    int         ram_mode = 0;
    logic [9:0] jump_v = '0;
    logic       prev_hs = 1'b1, prev_vs = 1'b1;
    int         hs_fall1, hs_fall2, hs_rise1, vs_fall1, vs_rise1;
    int         lit_cnt = 0, addr_nz = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int ram_r(input int mode, input int k);
        case (mode)
            1:       return 1000;
            2:       return (k == 5) ? 131071 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int ram_i(input int mode, input int k);
        case (mode)
            1:       return -1000;
            2:       return (k == 5) ? -131072 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_height(input int r, input int i);
        int m;
        m = ((r < 0) ? -r : r) + ((i < 0) ? -i : i);
        m = m / 256;
        return (m > 480) ? 480 : m;
    endfunction

    function automatic logic [13:0] exp_pixel(input int h, input int v);
        logic hs, vs, lit;
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
        lit = 1'b0;
        if (h < 640 && v < 480) begin
            lit = ((h % 4) != 3) && (v >= 480 - mheight[h / 4]);
        end
        return {hs, vs, 4'h0, (lit ? 4'hF : 4'h0), 4'h0};
    endfunction

    task automatic advance_model();
        if (rst) begin
            mh = 0; mv = 0; mcap = 0; mpend = 1'b0;
            foreach (mheight[k]) mheight[k] = 0;
        end else begin
            if (mcap != 0) begin
                mcap = (mcap == 161) ? 0 : mcap + 1;
            end else if (mpend && mh == 0 && mv == 480) begin
                mcap  = 1;
                mpend = 1'b0;
                foreach (mheight[k]) mheight[k] = exp_height(ram_r(ram_mode, k), ram_i(ram_mode, k));
            end else if (done) begin
                mpend = 1'b1;
            end
            if (mh == 799) begin
                mh = 0;
                mv = (mv == 524) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    // One clock: compare last cycle's prediction, predict this cycle, serve the RAM.
    task automatic tick(input bit chk);
        exp_t       e;
        logic [7:0] addr_s;
        if (chk && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("pixel", {18'd0, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, {18'd0, e.pix});
            check_eq("fft_addr", {24'd0, FFT_addr}, {24'd0, e.addr});
            if (prev_hs === 1'b1 && VGA_HS === 1'b0) begin
                if (hs_fall1 < 0) hs_fall1 = cyc;
                else if (hs_fall2 < 0) hs_fall2 = cyc;
            end
            if (prev_hs === 1'b0 && VGA_HS === 1'b1 && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = cyc;
            if (prev_vs === 1'b1 && VGA_VS === 1'b0 && vs_fall1 < 0) vs_fall1 = cyc;
            if (prev_vs === 1'b0 && VGA_VS === 1'b1 && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = cyc;
            if (VGA_G === 4'hF) lit_cnt++;
            if (FFT_addr !== 8'd0) addr_nz++;
        end
        prev_hs = VGA_HS;
        prev_vs = VGA_VS;
        if (chk) begin
            e.pix = rst ? 14'h3000 : exp_pixel(mh, mv);
            advance_model();
            e.addr = (mcap >= 1 && mcap <= 160) ? 8'(mcap - 1) : 8'd0;
            exp_q.push_back(e);
        end
        addr_s = FFT_addr;
        @(posedge vga_clk);
        #1;
        FFT_data_r = DW'(ram_r(ram_mode, int'(addr_s)));
        FFT_data_i = DW'(ram_i(ram_mode, int'(addr_s)));
        cyc++;
        @(negedge vga_clk);
    endtask

    task automatic reset_meas();
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; vs_fall1 = -1; vs_rise1 = -1;
    endtask

    // Fast-forward to mid-line v, then realign the model on the next HS falling edge.
    task automatic jump_to_line(input int v);
        jump_v = 10'(v);
        exp_q.delete();
        force dut.u_timing.hc_q = 10'd100;
        force dut.u_timing.vc_q = jump_v;
        tick(1'b0);
        release dut.u_timing.hc_q;
        release dut.u_timing.vc_q;
        for (int n = 0; n < 900 && VGA_HS !== 1'b0; n++) tick(1'b0);
        check_eq("hs_resync", {31'd0, VGA_HS}, 32'd0);
        mh = 657;
        mv = v;
        prev_hs = 1'b0;
    endtask

    task automatic run_until(input int v, input int h);
        for (int n = 0; n < 20000 && !(mv == v && mh == h); n++) tick(1'b1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1'b1);
        done = 1'b0;
    endtask

    initial begin
        foreach (mheight[k]) mheight[k] = 0;
        reset_meas();
        @(negedge vga_clk);
        repeat (3) tick(1'b1);
        rst = 1'b0;
        repeat (1700) tick(1'b1);
        check_eq("hs_low_len", 32'(hs_rise1 - hs_fall1), 32'd96);
        check_eq("hs_period", 32'(hs_fall2 - hs_fall1), 32'd800);

        jump_to_line(488);
        reset_meas();
        run_until(493, 0);
        check_eq("vs_low_len", 32'(vs_rise1 - vs_fall1), 32'd1600);

        // constant spectrum -> 7 px bars
        ram_mode = 1;
        jump_to_line(99);
        run_until(100, 0);
        pulse_done();
        jump_to_line(479);
        addr_nz = 0;
        run_until(481, 0);
        check_eq("addr_count", 32'(addr_nz), 32'd159);
        jump_to_line(471);
        lit_cnt = 0;
        run_until(480, 0);
        check_eq("lit_7px", 32'(lit_cnt), 32'd3360);

        // single saturated bin, second done during READ ignored
        ram_mode = 2;
        jump_to_line(200);
        pulse_done();
        jump_to_line(479);
        addr_nz = 0;
        for (int n = 0; n < 2000 && mcap != 50; n++) tick(1'b1);
        pulse_done();
        run_until(481, 0);
        check_eq("addr_count_2nd_done", 32'(addr_nz), 32'd159);
        jump_to_line(524);
        lit_cnt = 0;
        run_until(2, 0);
        check_eq("sat_top_rows", 32'(lit_cnt), 32'd6);
        jump_to_line(477);
        lit_cnt = 0;
        run_until(480, 0);
        check_eq("sat_bottom_rows", 32'(lit_cnt), 32'd6);
        jump_to_line(479);
        addr_nz = 0;
        run_until(481, 0);
        check_eq("no_recapture", 32'(addr_nz), 32'd0);

        // reset in the middle of a capture
        ram_mode = 1;
        jump_to_line(300);
        pulse_done();
        jump_to_line(479);
        for (int n = 0; n < 2000 && mcap != 80; n++) tick(1'b1);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        lit_cnt = 0;
        run_until(1, 0);
        check_eq("lit_rows_after_reset", 32'(lit_cnt), 32'd0);
        jump_to_line(471);
        lit_cnt = 0;
        run_until(480, 0);
        check_eq("lit_bottom_after_reset", 32'(lit_cnt), 32'd0);
        jump_to_line(479);
        addr_nz = 0;
        run_until(481, 0);
        check_eq("no_capture_after_reset", 32'(addr_nz), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_generator.md
VGA_GENERATOR -- requirements
Module: vga_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 18: width of each signed FFT real/imaginary sample.
REQ-002 Parameter ADDR_WIDTH, default 9: log2 of FFT length; FFT_addr is ADDR_WIDTH-1 bits wide (256 bins).
REQ-003 Parameter MAG_SHIFT, default DATA_WIDTH-10: right shift that converts magnitude to bar height.
REQ-004 vga_clk  input  1  sole clock (25 MHz pixel clock); all logic is rising-edge on vga_clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 done  input  1  one-cycle pulse: a new FFT result frame is ready in the external FFT RAM.
REQ-007 FFT_data_r  input  DATA_WIDTH  signed real part of the addressed bin, valid one cycle after FFT_addr.
REQ-008 FFT_data_i  input  DATA_WIDTH  signed imaginary part, same timing as FFT_data_r.
REQ-009 FFT_addr  output  ADDR_WIDTH-1  bin address into the external FFT RAM.
REQ-010 VGA_R, VGA_G, VGA_B  output  4 each  pixel colour.
REQ-011 VGA_HS, VGA_VS  output  1 each  horizontal/vertical sync, active-low.

Function
REQ-012 Horizontal counter hc counts 0..799 (640 visible, 16 front porch, 96 sync, 48 back porch), then wraps to 0.
REQ-013 Vertical counter vc increments when hc wraps and counts 0..524 (480 visible, 10 front porch, 2 sync, 33 back porch), then wraps to 0.
REQ-014 VGA_HS is low for hc 656..751; VGA_VS is low for vc 490..491; both are high otherwise.
REQ-015 All VGA outputs are registered with one cycle of latency from the counters; syncs and colour share the same pipeline stage.
REQ-016 A height buffer holds 160 entries of 9 bits (0..480); bar b covers columns 4b..4b+3.
REQ-017 Pixel (x=hc, y=vc) in the visible area is lit when x[1:0]!=3 and y >= 480-height[x>>2]; lit = R 0, G F, B 0; unlit = all 0.
REQ-018 RGB are 0 whenever (hc,vc) is outside the visible area.
REQ-019 A done pulse sets a pending flag; done pulses arriving while pending or while a capture is running are ignored.
REQ-020 Capture FSM states: IDLE, READ, DRAIN; IDLE->READ when pending is set and the cycle has hc==0, vc==480 (start of vertical blank); pending is cleared on that transition.
REQ-021 In READ, FFT_addr steps 0..159, one address per cycle; after address 159, the FSM enters DRAIN for one cycle to absorb RAM latency, then returns to IDLE.
REQ-022 Data returned for address k, one cycle later, is written to height[k]; writes occur only during vertical blank, so no frame tears.
REQ-023 Magnitude = |FFT_data_r| + |FFT_data_i|, computed at DATA_WIDTH+1 bits so that |-2^(DATA_WIDTH-1)| is exact.
REQ-024 height = min(magnitude >> MAG_SHIFT, 480).
REQ-025 FFT_addr holds 0 outside READ.

Reset
REQ-026 While rst is high at a clock edge: hc=vc=0, FSM=IDLE, pending=0, FFT_addr=0, all heights=0, RGB=0, VGA_HS=VGA_VS=1.
REQ-027 Reset asserted mid-capture aborts the capture; entries already written are cleared to 0.

Structure
REQ-028 VGA timing constants (visible, porch, sync, totals), bar count 160, bar width 4 and the FSM state enum belong in a shared package.
REQ-029 A single sub-module vga_timing contains hc/vc, sync and visible flags; the capture FSM, magnitude logic, height buffer and pixel logic stay in vga_generator.

Verification
REQ-030 Reset held 3 cycles, then released -> VGA_HS=VGA_VS=1 and RGB=0 on the first cycle; first HS low pulse lasts exactly 96 cycles; HS period is 800 cycles.
REQ-031 Run 2 frames -> VS low for exactly 1600 cycles (2 lines) every 420000 cycles; RGB=0 in all blanking cycles.
REQ-032 done pulsed at vc=100; bench RAM returns r=1000, i=-1000 for every bin -> capture starts at vc=480, hc=0; FFT_addr runs 0..159; next frame shows all bars 7 px tall (rows 473..479 green; column 3 of each bar black).
REQ-033 Bin 5 returns r=2^17-1, i=-2^17, others 0 -> height[5]=480 (saturated), bar 5 is lit on all rows 0..479 at columns 20..22, other bars are dark.
REQ-034 Second done pulse during READ -> ignored: exactly 160 addresses issued and pending=0 afterwards.
REQ-035 rst asserted during READ -> FFT_addr=0, FSM=IDLE, all heights 0 and no lit pixels in the following frame.
